// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 decoder: drains the receiver FIFO and turns
// E0/F0/E1 prefix sequences into key events with modifier tracking.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       kb_ready,
    input  logic [7:0] kb_data,
    input  logic       kb_overflow,
    output logic       rdn,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    input  logic       ev_ack,
    output logic       shift,
    output logic       ctrl,
    output logic       alt,
    output logic       caps_lock,
    output logic [2:0] err,
    input  logic       err_clr
);

    typedef enum logic [2:0] {
        S_BASE,
        S_E0,
        S_F0,
        S_E0F0,
        S_SKIP
    } state_t;

    state_t          state, state_nx;
    logic [2:0]      skip, skip_nx;
    logic [TO_W-1:0] to_cnt;
    logic            take, timeout, bad_byte;
    logic            emit, emit_ext, emit_brk;
    logic [7:0]      emit_code;
    logic            is_e0, is_f0, is_e1, is_drop, is_bad, is_fake;
    logic            lshift, rshift, lctrl, rctrl, lalt, ralt, caps_held;

    // A byte is taken only while no event is waiting for the consumer.
    assign take = kb_ready & ~ev_valid & clrn;
    assign rdn  = ~take;

    assign timeout = (state != S_BASE) && !take &&
                     (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    assign is_e0   = (kb_data == 8'hE0);
    assign is_f0   = (kb_data == 8'hF0);
    assign is_e1   = (kb_data == 8'hE1);
    assign is_drop = kb_data inside {8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFD};
    assign is_bad  = kb_data inside {8'h00, 8'hFF};
    assign is_fake = kb_data inside {8'h12, 8'h59};

    // Prefix parser: next state, skip count and the event to emit.
    always_comb begin
        state_nx  = state;
        skip_nx   = skip;
        emit      = 1'b0;
        emit_code = kb_data;
        emit_ext  = 1'b0;
        emit_brk  = 1'b0;
        bad_byte  = 1'b0;
        if (take) begin
            unique case (state)
                S_BASE: begin
                    unique case (1'b1)
                        is_e0:   state_nx = S_E0;
                        is_f0:   state_nx = S_F0;
                        is_e1: begin
                            state_nx = S_SKIP;
                            skip_nx  = 3'd7;
                        end
                        is_drop: ;
                        is_bad:  bad_byte = 1'b1;
                        default: emit = 1'b1;
                    endcase
                end
                S_E0: begin
                    if (is_f0) begin
                        state_nx = S_E0F0;
                    end else begin
                        state_nx = S_BASE;
                        emit     = ~is_fake;
                        emit_ext = 1'b1;
                    end
                end
                S_F0: begin
                    state_nx = S_BASE;
                    emit     = 1'b1;
                    emit_brk = 1'b1;
                end
                S_E0F0: begin
                    state_nx = S_BASE;
                    emit     = ~is_fake;
                    emit_ext = 1'b1;
                    emit_brk = 1'b1;
                end
                S_SKIP: begin
                    skip_nx = skip - 3'd1;
                    if (skip == 3'd1) begin
                        state_nx  = S_BASE;
                        emit      = 1'b1;
                        emit_code = 8'hE1;
                    end
                end
                default: state_nx = S_BASE;
            endcase
        end else if (timeout) begin
            state_nx = S_BASE;
            skip_nx  = 3'd0;
        end
    end

    // Prefix state and Pause skip counter.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= S_BASE;
            skip  <= 3'd0;
        end else begin
            state <= state_nx;
            skip  <= skip_nx;
        end
    end

    // Idle counter used to abandon a stalled prefix sequence.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            to_cnt <= '0;
        end else if (state == S_BASE || take || timeout) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Event register, held until the consumer acknowledges it.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ev_valid <= 1'b0;
            ev_code  <= 8'h00;
            ev_ext   <= 1'b0;
            ev_break <= 1'b0;
        end else if (emit) begin
            ev_valid <= 1'b1;
            ev_code  <= emit_code;
            ev_ext   <= emit_ext;
            ev_break <= emit_brk;
        end else if (ev_ack) begin
            ev_valid <= 1'b0;
        end
    end

    // Per-side modifier flops and caps lock toggle on fresh press only.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            lctrl     <= 1'b0;
            rctrl     <= 1'b0;
            lalt      <= 1'b0;
            ralt      <= 1'b0;
            caps_held <= 1'b0;
            caps_lock <= 1'b0;
        end else if (emit) begin
            if (!emit_ext && emit_code == 8'h12) lshift <= ~emit_brk;
            if (!emit_ext && emit_code == 8'h59) rshift <= ~emit_brk;
            if (!emit_ext && emit_code == 8'h14) lctrl  <= ~emit_brk;
            if (emit_ext && emit_code == 8'h14)  rctrl  <= ~emit_brk;
            if (!emit_ext && emit_code == 8'h11) lalt   <= ~emit_brk;
            if (emit_ext && emit_code == 8'h11)  ralt   <= ~emit_brk;
            if (!emit_ext && emit_code == 8'h58) begin
                if (!emit_brk && !caps_held) caps_lock <= ~caps_lock;
                caps_held <= ~emit_brk;
            end
        end
    end

    // Sticky error bits; a new error outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            err <= 3'b000;
        end else begin
            err <= (err_clr ? 3'b000 : err) | {timeout, kb_overflow, bad_byte};
        end
    end

    assign shift = lshift | rshift;
    assign ctrl  = lctrl | rctrl;
    assign alt   = lalt | ralt;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed sequences plus random key
// traffic compared against a byte-queue reference model.
module tb_ps2_key_decoder;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       kb_ready = 1'b0;
    logic [7:0] kb_data = 8'h00;
    logic       kb_overflow = 1'b0;
    logic       ev_ack = 1'b0;
    logic       err_clr = 1'b0;
    logic       rdn, ev_valid, ev_ext, ev_break;
    logic       shift, ctrl, alt, caps_lock;
    logic [7:0] ev_code;
    logic [2:0] err;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: pending prefix bytes, keys held, flags.
    logic [7:0] q[$];
    bit         down[512];
    bit         m_caps;
    logic [2:0] m_err;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
        .clk(clk), .clrn(clrn), .kb_ready(kb_ready), .kb_data(kb_data),
        .kb_overflow(kb_overflow), .rdn(rdn), .ev_valid(ev_valid),
        .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break),
        .ev_ack(ev_ack), .shift(shift), .ctrl(ctrl), .alt(alt),
        .caps_lock(caps_lock), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        foreach (down[i]) down[i] = 1'b0;
        m_caps = 1'b0;
        m_err  = 3'b000;
    endtask

    // Interpret the byte stream by collecting a whole sequence first.
    task automatic model_byte(input logic [7:0] b, output bit ev,
                              output logic [7:0] c, output bit x,
                              output bit k);
        ev = 1'b0; c = 8'h00; x = 1'b0; k = 1'b0;
        q.push_back(b);
        if (q[0] == 8'hE1) begin
            if (q.size() == 8) begin
                ev = 1'b1;
                c  = 8'hE1;
                q.delete();
            end
        end else if (q.size() == 1 && (b == 8'hE0 || b == 8'hF0)) begin
        end else if (q.size() == 2 && q[0] == 8'hE0 && b == 8'hF0) begin
        end else if (q.size() == 1 &&
                     b inside {8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFD}) begin
            q.delete();
        end else if (q.size() == 1 && (b == 8'h00 || b == 8'hFF)) begin
            m_err[0] = 1'b1;
            q.delete();
        end else begin
            x = (q[0] == 8'hE0);
            k = (q.size() >= 2 && q[q.size() - 2] == 8'hF0);
            q.delete();
            if (!(x && (b == 8'h12 || b == 8'h59))) begin
                ev = 1'b1;
                c  = b;
                if (!x && b == 8'h58 && !k && !down[9'h058])
                    m_caps = ~m_caps;
                down[{x, b}] = ~k;
            end
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_shift"}, shift, down[9'h012] | down[9'h059]);
        check({tag, "_ctrl"}, ctrl, down[9'h014] | down[9'h114]);
        check({tag, "_alt"}, alt, down[9'h011] | down[9'h111]);
        check({tag, "_caps"}, caps_lock, m_caps);
        check({tag, "_err"}, err, m_err);
    endtask

    task automatic do_ack(input int hold);
        repeat (hold) begin
            @(negedge clk);
            check("ev_hold", ev_valid, 1);
        end
        @(negedge clk);
        ev_ack = 1'b1;
        @(posedge clk);
        #1 ev_ack = 1'b0;
        @(negedge clk);
        check("ack_clear", ev_valid, 0);
    endtask

    // Present one byte, let the DUT take it, then compare with the model.
    task automatic send(input logic [7:0] b, input bit auto_ack);
        bit         ev, x, k;
        logic [7:0] c;
        int         t;
        @(negedge clk);
        kb_data  = b;
        kb_ready = 1'b1;
        #1;
        t = 0;
        while (rdn !== 1'b0 && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("take_byte", rdn, 0);
        @(posedge clk);
        #1 kb_ready = 1'b0;
        model_byte(b, ev, c, x, k);
        @(negedge clk);
        check("ev_valid", ev_valid, ev);
        if (ev) begin
            check("ev_code", ev_code, c);
            check("ev_ext", ev_ext, x);
            check("ev_break", ev_break, k);
        end
        check_state("mod");
        if (auto_ack && ev_valid === 1'b1)
            do_ack($urandom_range(0, 3));
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send(s[i], 1'b1);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        m_err = 3'b000;
        @(negedge clk);
        check("err_clr", err, m_err);
    endtask

    task automatic random_key();
        logic [7:0] code;
        bit         ext, brk;
        int         r;
        logic [7:0] mods[5] = '{8'h12, 8'h59, 8'h14, 8'h11, 8'h58};
        r = $urandom_range(0, 19);
        if (r == 0) begin
            send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14,
                       8'hF0, 8'h77});
        end else if (r == 1) begin
            send(8'hAA, 1'b1);
        end else if (r == 2) begin
            send(($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00, 1'b1);
        end else if (r == 3) begin
            send(8'hE0, 1'b1);
            if ($urandom_range(0, 1) != 0) send(8'hF0, 1'b1);
            send(($urandom_range(0, 1) != 0) ? 8'h59 : 8'h12, 1'b1);
        end else begin
            if ($urandom_range(0, 1) != 0)
                code = mods[$urandom_range(0, 4)];
            else
                code = 8'($urandom_range(1, 8'h83));
            ext = ($urandom_range(0, 1) != 0);
            brk = ($urandom_range(0, 1) != 0);
            if (code inside {8'h12, 8'h59, 8'h58}) ext = 1'b0;
            if (ext) send(8'hE0, 1'b1);
            if (brk) send(8'hF0, 1'b1);
            send(code, 1'b1);
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    initial begin
        model_reset();
        kb_ready = 1'b1;
        kb_data  = 8'h1C;
        #3;
        check("rst_rdn", rdn, 1);
        check("rst_valid", ev_valid, 0);
        check("rst_code", ev_code, 0);
        check_state("rst");
        kb_ready = 1'b0;
        repeat (2) @(negedge clk);
        clrn = 1'b1;

        // Make event then backpressure while it is unacknowledged.
        send(8'h1C, 1'b0);
        @(negedge clk);
        kb_data  = 8'h22;
        kb_ready = 1'b1;
        #1;
        repeat (5) begin
            check("bp_rdn", rdn, 1);
            check("bp_valid", ev_valid, 1);
            @(negedge clk);
            #1;
        end
        kb_ready = 1'b0;
        do_ack(0);

        // Break and extended break.
        send_seq('{8'hF0, 8'h1C, 8'hE0, 8'hF0, 8'h75});

        // Shift with the fake-shift sequence in between.
        send(8'h12, 1'b1);
        check("shift_on", shift, 1);
        send_seq('{8'hE0, 8'h12});
        check("shift_fake", shift, 1);
        send_seq('{8'hF0, 8'h12});
        check("shift_off", shift, 0);

        // Caps lock: press, repeat, release, press.
        send_seq('{8'h58, 8'h58, 8'hF0, 8'h58});
        check("caps_held", caps_lock, 1);
        send(8'h58, 1'b1);
        check("caps_again", caps_lock, 0);

        // Pause sequence yields a single event.
        send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77});

        // Abandoned prefix times out back to the base state.
        send(8'hE0, 1'b1);
        repeat (TO + 4) @(negedge clk);
        q.delete();
        m_err[2] = 1'b1;
        check("timeout_err", err, 3'b100);
        send(8'h1C, 1'b1);
        pulse_clr();
        @(negedge clk);
        kb_overflow = 1'b1;
        @(posedge clk);
        #1 kb_overflow = 1'b0;
        m_err[1] = 1'b1;
        @(negedge clk);
        check("overflow_err", err, 3'b010);
        pulse_clr();

        // Random traffic against the model.
        for (int i = 0; i < 150; i++) random_key();
        check_state("rand_end");
        pulse_clr();

        // Reset in the middle of a prefix discards it.
        send(8'hE0, 1'b1);
        @(negedge clk);
        clrn = 1'b0;
        #2;
        model_reset();
        check("midrst_valid", ev_valid, 0);
        check_state("midrst");
        @(negedge clk);
        clrn = 1'b1;
        send(8'h1C, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Controller that drains the PS/2 receiver byte FIFO by driving its active-low `rdn` read strobe.
- Parses scan-code set 2 prefix sequences (E0 extended, F0 break, E1 Pause) into single key events with a valid/ack handshake to the CPU/MIO side.
- Tracks modifier state (shift, ctrl, alt, caps lock) and flags error conditions.
- Sits between mio_ps2 and the CPU I/O register bank.

Parameters:
- TIMEOUT_CYCLES, 1000000, idle cycles in a prefix state before resync to BASE (20 ms at 50 MHz).
- TO_W, 20, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, 50 MHz
- clrn  in  1  reset, asynchronous, active-low
- kb_ready  in  1  receiver FIFO not empty
- kb_data  in  8  receiver FIFO head byte, combinational from the receiver
- kb_overflow  in  1  receiver FIFO overflow flag
- rdn  out  1  read strobe to receiver, active-low, combinational
- ev_valid  out  1  key event available
- ev_code  out  8  base scan code; 8'hE1 for Pause
- ev_ext  out  1  event was E0-prefixed
- ev_break  out  1  1 = key release, 0 = make/typematic repeat
- ev_ack  in  1  consumer takes the event
- shift  out  1  left or right shift held
- ctrl  out  1  left or right ctrl held
- alt  out  1  left or right alt held
- caps_lock  out  1  caps lock toggle state
- err  out  3  sticky error bits: {timeout, kb_overflow seen, 00/FF overrun byte}
- err_clr  in  1  clears err next edge

Behaviour:
- Reset (clrn=0, async): prefix state BASE, ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, all modifiers 0, caps_lock=0, err=0, timeout counter 0, skip counter 0. rdn=1 during reset.
- Consume rule: `take = kb_ready & ~ev_valid & clrn`; `rdn = ~take`. Byte kb_data is processed at the same edge the receiver advances its read pointer. Throughput is at most 1 byte per clock. No read occurs while an event is pending (backpressure into the receiver FIFO).
- Prefix states: BASE, E0, F0, E0F0, SKIP.
  - BASE: E0 -> E0; F0 -> F0; E1 -> SKIP with skip=7; AA/FA/EE/FC/FD dropped; 00/FF dropped and err[0] set; any other byte emits a make event (ext=0).
  - E0: F0 -> E0F0; other byte emits an ext make event and returns to BASE.
  - F0: byte emits a break event (ext=0) -> BASE.
  - E0F0: byte emits an ext break event -> BASE.
  - SKIP: each consumed byte decrements skip. On the byte where skip==1: emit ev_code=E1, ext=0, break=0, then -> BASE.
- Fake-shift suppression: ext code 12 or 59 (make or break) emits no event, changes no modifier, and returns to BASE.
- Emit: ev_valid<=1 and fields registered at the consuming edge, so latency is 1 cycle from byte acceptance. ev_valid holds until a cycle with ev_ack=1, then clears at that edge. The next byte can be accepted 1 cycle after the clear. ev_ack while ev_valid=0 is ignored.
- Modifiers update at the emitting edge:
  - shift = lshift(12) | rshift(59), ext=0.
  - ctrl = 14 (ext 0 or 1).
  - alt = 11 (ext 0 or 1).
  - Each side is held as a separate flop; an output is the OR of both sides.
  - caps_lock toggles on make of 58 only if the internal caps_held flop is 0. caps_held is set on make 58 and cleared on break 58, so typematic repeat does not toggle.
- Timeout: the counter runs only in states other than BASE and clears on every consumed byte. On reaching TIMEOUT_CYCLES-1: state -> BASE, skip=0, err[2] set.
- kb_overflow=1 in any cycle sets err[1]. State is not altered.
- err_clr=1 clears all err bits at the next edge. A new error in the same cycle wins (bit stays set).
- Reset mid-sequence discards the partial prefix and any pending event.

Test Plan:
- Feed 1C -> rdn low 1 cycle; next cycle ev_valid=1, code=1C, ext=0, break=0. Hold ev_ack=0 for 5 cycles -> ev_valid stays 1, rdn stays 1 with kb_ready=1.
- Feed F0 1C, then E0 F0 75 -> two events: {1C, ext0, brk1} and {75, ext1, brk1}. No event for prefix bytes.
- Feed 12, then E0 12, then F0 12 -> shift=1 after the first event; E0 12 yields no event and shift stays 1; shift=0 after the break event.
- Feed 58, 58, F0 58, 58 -> caps_lock goes 1, stays 1 on the repeat, stays 1 on the break, goes 0 on the second press. Four events emitted.
- Feed E1 14 77 E1 F0 14 F0 77 back-to-back -> exactly one event, code=E1, emitted after the 8th byte.
- Feed E0 then no bytes for TIMEOUT_CYCLES (override to 16) -> err=3'b100 and state BASE. A following 1C gives ext=0. Then pulse err_clr -> err=0. Also drive kb_overflow=1 for 1 cycle -> err[1]=1.
